// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decode/writeback/redirect bundle between the pipeline and its hazard controller
//   decode  : dec_valid, dec_rs1/rs2/rd, dec_rs1en/rs2en/rden, dec_drain
//   wb      : wb_en, wb_rd
//   redirect: redirect_valid, redirect_pc
//   control : stall, issue, flush, fetch_redirect, fetch_pc, busy, ctrl_state
//   slave modport is the controller side, master is the pipeline side
interface pipe_hazard_ctrl_if;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_rs1en;
    logic        dec_rs2en;
    logic        dec_rden;
    logic        dec_drain;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        issue;
    logic        flush;
    logic        fetch_redirect;
    logic [31:0] fetch_pc;
    logic [31:0] busy;
    logic [1:0]  ctrl_state;

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rs1en, dec_rs2en, dec_rden, dec_drain,
        input  wb_en, wb_rd, redirect_valid, redirect_pc,
        output stall, issue, flush, fetch_redirect, fetch_pc, busy, ctrl_state
    );

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rs1en, dec_rs2en, dec_rden, dec_drain,
        output wb_en, wb_rd, redirect_valid, redirect_pc,
        input  stall, issue, flush, fetch_redirect, fetch_pc, busy, ctrl_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: register scoreboard, RAW/WAW stall, drain-before-SYSTEM and multi-cycle redirect flush
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : pipe_hazard_ctrl_if.slave (decode, writeback and redirect in; stall/issue/flush/fetch/scoreboard out)
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input logic             clk,
    input logic             reset,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] busy_q;
    logic        flush_q;
    logic        fetch_redirect_q;
    logic [31:0] fetch_pc_q;
    logic        haz;
    logic        any_busy;
    logic        issue;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] busy_nxt;

    always_comb begin
        haz      = (bus.dec_rs1en & busy_q[bus.dec_rs1]) |
                   (bus.dec_rs2en & busy_q[bus.dec_rs2]) |
                   (bus.dec_rden  & busy_q[bus.dec_rd]);
        any_busy = |busy_q;
        issue    = bus.dec_valid & (state == RUN) & !haz & !bus.redirect_valid & !(bus.dec_drain & any_busy);
        set_mask = (issue & bus.dec_rden & (bus.dec_rd != 5'd0)) ? (32'd1 << bus.dec_rd) : 32'd0;
        clr_mask = bus.wb_en ? (32'd1 << bus.wb_rd) : 32'd0;
        // set is applied after clear so a same-bit collision leaves the bit set; x0 never tracks
        busy_nxt = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= RUN;
            cnt              <= 4'd0;
            flush_q          <= 1'b0;
            fetch_redirect_q <= 1'b0;
            fetch_pc_q       <= 32'd0;
        end else if (bus.redirect_valid) begin
            state            <= FLUSH;
            cnt              <= 4'(FLUSH_CYCLES - 1);
            flush_q          <= 1'b1;
            fetch_redirect_q <= 1'b1;
            fetch_pc_q       <= bus.redirect_pc;
        end else begin
            fetch_redirect_q <= 1'b0;
            case (state)
                RUN: begin
                    if (bus.dec_valid & bus.dec_drain & any_busy)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // the drain instruction issues in the RUN cycle that follows
                    if (!any_busy)
                        state <= RUN;
                end
                FLUSH: begin
                    if (cnt == 4'd0) begin
                        state   <= RUN;
                        flush_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.issue          = issue;
    assign bus.stall          = bus.dec_valid & !issue & !bus.redirect_valid;
    assign bus.flush          = flush_q;
    assign bus.fetch_redirect = fetch_redirect_q;
    assign bus.fetch_pc       = fetch_pc_q;
    assign bus.busy           = busy_q;
    assign bus.ctrl_state     = state;
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline controller between the decode stage and execute. It keeps a register scoreboard of in-flight writes and stalls decode on RAW/WAW hazards. It drains the pipeline before SYSTEM/MISC-MEM instructions, and sequences a multi-cycle flush of fetch/decode when execute redirects the PC. It drives the decode `flush` input and the fetch redirect.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: number of consecutive cycles `flush` is held after a redirect. Legal range 1–15.

Ports:
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `dec_valid`, input, 1: decode output holds a valid instruction.
- `dec_rs1`, `dec_rs2`, `dec_rd`, input, 5 each: register indices from decode.
- `dec_rs1en`, `dec_rs2en`, `dec_rden`, input, 1 each: register-use enables from decode.
- `dec_drain`, input, 1: decoded instruction is SYSTEM or MISC-MEM and must issue into an empty pipeline.
- `wb_en`, input, 1: writeback commits a register write this cycle.
- `wb_rd`, input, 5: writeback destination register.
- `redirect_valid`, input, 1: execute resolved a taken branch or jump this cycle.
- `redirect_pc`, input, 32: target PC for the redirect.
- `stall`, output, 1: combinational. Holds fetch and decode.
- `issue`, output, 1: combinational. Decode instruction advances to execute this cycle.
- `flush`, output, 1: registered. Squashes decode contents.
- `fetch_redirect`, output, 1: registered. One-cycle PC-load strobe to fetch.
- `fetch_pc`, output, 32: registered. PC value loaded by fetch.
- `busy`, output, 32: registered scoreboard. Bit n set means xn has a pending write.
- `ctrl_state`, output, 2: registered. RUN=0, DRAIN=1, FLUSH=2.

## Operation
- Hazard term `haz` is the OR of:
  - `dec_rs1en & busy[dec_rs1]`
  - `dec_rs2en & busy[dec_rs2]`
  - `dec_rden & busy[dec_rd]`, the WAW stall. It guarantees at most one writer per register in flight.
- `busy[0]` is hard-wired to 0. An issued `dec_rd`=0 never sets a bit, and `wb_rd`=0 is ignored.
- `issue` = `dec_valid & (ctrl_state==RUN) & !haz & !redirect_valid & !(dec_drain & busy!=0)`.
- `stall` = `dec_valid & !issue & !redirect_valid`.
- Scoreboard update at each clock edge:
  - Set `busy[dec_rd]` when `issue & dec_rden & dec_rd!=0`.
  - Clear `busy[wb_rd]` when `wb_en`.
  - If set and clear hit the same bit in the same cycle, set wins. The WAW stall makes this unreachable in legal operation.
- FSM, with redirect taking priority in every state:
  - Any state with `redirect_valid`: go to FLUSH. Counter ← `FLUSH_CYCLES-1`, `flush`←1, `fetch_redirect`←1, `fetch_pc`←`redirect_pc`.
  - RUN with `dec_valid & dec_drain & busy!=0`: go to DRAIN.
  - DRAIN: stays while `busy!=0`. Returns to RUN on the edge where the registered `busy`==0. The drain instruction issues in the following RUN cycle.
  - FLUSH: `flush`=1 each cycle. The counter decrements each cycle. When the counter is 0 and there is no redirect, go to RUN and `flush`←0.
  - A redirect arriving during FLUSH restarts the counter and reloads `fetch_pc`.
- The scoreboard is not altered by a redirect. All instructions already issued are older than the redirecting branch, because execute resolves in the cycle after issue and `issue` is suppressed during `redirect_valid`.
- Reset mid-operation returns to RUN immediately. All in-flight state is discarded.

## Timing
- Reset values:
  - `busy`=0, `ctrl_state`=RUN, counter=0.
  - `flush`=0, `fetch_redirect`=0, `fetch_pc`=32'h0.
  - `stall` and `issue` follow their inputs combinationally.
- Hazard to issue:
  - A `wb_en` to xn in cycle t clears `busy[n]` at edge t+1.
  - A dependent instruction held in decode asserts `issue` in cycle t+1. There is no same-cycle bypass.
- Redirect:
  - `redirect_valid` in cycle t gives `fetch_redirect`=1 in cycle t+1 only.
  - `flush`=1 in cycles t+1 … t+`FLUSH_CYCLES`.
  - `ctrl_state`=RUN from cycle t+`FLUSH_CYCLES`+1.
- `issue` is 0 in every cycle where `redirect_valid`=1 or `ctrl_state`≠RUN.

## Test plan
- After reset, check all outputs at reset values. Issue ADD rd=5 with no hazards: `issue`=1 in the same cycle and `busy`=32'h20 next cycle.
- RAW: x5 is busy and decode has rs1=5. Check `stall`=1 until `wb_en`/`wb_rd`=5 at cycle t, then `issue`=1 at cycle t+1 and `busy[5]` clears.
- WAW and x0:
  - With x7 busy, an instruction with rd=7 and no sources stalls.
  - An instruction with rd=0 issues and leaves `busy`=0.
  - `wb_rd`=0 causes no change.
- Drain: `busy`=32'h0000_0C00 and `dec_drain`=1. Expect DRAIN. Write back x10 then x11; `ctrl_state` returns to RUN one cycle after the last clear and `issue`=1 on that RUN cycle.
- Redirect with FLUSH_CYCLES=2: `redirect_pc`=32'h0000_0100 in cycle t.
  - `fetch_redirect`=1 and `fetch_pc`=0x100 in cycle t+1.
  - `flush`=1 in cycles t+1 and t+2.
  - RUN in cycle t+3.
  - Then issue a second redirect to 0x200 at cycle t+2: the counter restarts and `fetch_pc`=0x200.
- Assert `reset` low during FLUSH and during DRAIN: the state returns to RUN, `busy`=0 and `flush`=0 immediately (asynchronously).
